// File: rtl/part_74s163_chain_pkg.sv
// Shared constants and types for the 74S163-style counter chain.
package part_74s163_chain_pkg;

    // Width of one counter stage and its terminal (all-ones) value.
    localparam int          STAGE_W    = 4;
    localparam logic [3:0]  STAGE_ONES = 4'hF;

    typedef logic [STAGE_W-1:0] nibble_t;

endpackage : part_74s163_chain_pkg

// File: rtl/part_74s163_chain_if.sv
// Control/data bundle of the counter chain.
// master drives load/enable/data; slave is the counter chain itself.
interface part_74s163_chain_if #(
    parameter int STAGES = 2
);
    logic                  LOAD_N;
    logic                  ENP;
    logic                  ENT;
    logic [4*STAGES-1:0]   D;
    logic [4*STAGES-1:0]   Q;
    logic                  RCO;
    logic                  TC;

    modport master (
        output LOAD_N, ENP, ENT, D,
        input  Q, RCO, TC
    );

    modport slave (
        input  LOAD_N, ENP, ENT, D,
        output Q, RCO, TC
    );
endinterface : part_74s163_chain_if

// File: rtl/part_74s163_chain_stage.sv
// One 74S163-style 4-bit synchronous binary counter stage.
// Priority: clear, then load, then count (ENP & ENT), else hold.
// RCO is combinational and ignores ENP so a paused low stage still
// propagates its carry enable to the stages above it.
module part_74s163
    import part_74s163_chain_pkg::*;
(
    input  logic    CLK,
    input  logic    CLR_N,
    input  logic    LOAD_N,
    input  logic    ENP,
    input  logic    ENT,
    input  nibble_t D,
    output nibble_t Q,
    output logic    RCO
);

    nibble_t cnt_q;
    nibble_t cnt_d;

    // Next count: load beats counting; counting wraps F -> 0 naturally.
    always_comb begin
        cnt_d = cnt_q;
        if (!LOAD_N) begin
            cnt_d = D;
        end else if (ENP && ENT) begin
            cnt_d = cnt_q + nibble_t'(1);
        end
    end

    // Count register with synchronous clear taking priority over everything.
    always_ff @(posedge CLK) begin
        if (!CLR_N) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign Q   = cnt_q;
    assign RCO = ENT && (cnt_q == STAGE_ONES);

endmodule : part_74s163

// File: rtl/part_74s163_chain.sv
// Cascade of 74S163-style counter stages with optional auto-reload
// (programmable divider) and a registered terminal-count pulse.
module part_74s163_chain
    import part_74s163_chain_pkg::*;
#(
    parameter int STAGES      = 2,
    parameter bit AUTO_RELOAD = 1'b0
) (
    input  logic                CLK,
    input  logic                CLR_N,
    part_74s163_chain_if.slave  bus
);

    localparam int W = STAGE_W * STAGES;

    logic [STAGES:0] entChain;
    logic [W-1:0]    qVec;
    logic            reloadHit;
    logic            loadNEff;
    logic            tc_q;
    logic            tc_d;

    // Stage 0 takes the chip ENT; each higher stage is enabled by the carry below.
    assign entChain[0] = bus.ENT;

    // In divider mode the chain reloads D on the enabled terminal count.
    if (AUTO_RELOAD) begin : g_reload
        assign reloadHit = entChain[STAGES] & bus.ENP;
    end else begin : g_noReload
        assign reloadHit = 1'b0;
    end

    assign loadNEff = bus.LOAD_N & ~reloadHit;

    for (genvar i = 0; i < STAGES; i++) begin : g_stage
        part_74s163 u_stage (
            .CLK    (CLK),
            .CLR_N  (CLR_N),
            .LOAD_N (loadNEff),
            .ENP    (bus.ENP),
            .ENT    (entChain[i]),
            .D      (bus.D[i*STAGE_W +: STAGE_W]),
            .Q      (qVec[i*STAGE_W +: STAGE_W]),
            .RCO    (entChain[i+1])
        );
    end

    // Terminal-count pulse: flags the edge at which the chain wrapped or reloaded.
    assign tc_d = entChain[STAGES] & bus.ENP;

    // TC register, cleared together with the counter.
    always_ff @(posedge CLK) begin
        if (!CLR_N) begin
            tc_q <= 1'b0;
        end else begin
            tc_q <= tc_d;
        end
    end

    assign bus.Q   = qVec;
    assign bus.RCO = entChain[STAGES];
    assign bus.TC  = tc_q;

endmodule : part_74s163_chain
